// File: rtl/pipeline_pkg.sv
// Shared loader definitions: FSM state encoding, header/word geometry constants.
package pipeline_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERROR
    } ldr_state_e;

    localparam int unsigned LDR_HDR_W          = 16;
    localparam int unsigned LDR_BYTES_PER_WORD = 4;

    // States in which a Start pulse begins a new load.
    function automatic logic ldr_start_ok(input ldr_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Big-endian byte-to-word packer: 2-bit byte counter plus shift register.
// word always shows the word that the current byte would complete; full flags the 4th push.
module byte_packer
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sh_q, sh_d;

    assign word = {sh_q, byte_in};
    assign full = push && (cnt_q == 2'(LDR_BYTES_PER_WORD - 1));

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clr) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (push) begin
            cnt_d = cnt_q + 2'd1;
            sh_d  = word[23:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: header + byte stream -> sequential INST_MEM word writes, then CPU release.
// Optional trailer checksum byte enabled by defining INST_MEM_LOADER_CHECKSUM_EN.
module inst_mem_loader
    import pipeline_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned WORDS_MAX = 256
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          Start,
    input  logic          In_Valid,
    input  logic [7:0]    In_Byte,
    output logic          In_Ready,
    output logic          Wr_En,
    output logic [AW-1:0] Wr_Addr,
    output logic [31:0]   Wr_Data,
    output logic          Cpu_En,
    output logic          Cpu_Clr_N,
    output logic          Busy,
    output logic          Done,
    output logic          Err
);

    ldr_state_e state_q, state_d;

    logic [LDR_HDR_W-1:0] hdr_q, hdr_d;
    logic [AW-1:0]        word_cnt_q, word_cnt_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [31:0]          wr_data_q, wr_data_d;

    logic                 xfer;
    logic [LDR_HDR_W-1:0] hdr_full;
    logic                 hdr_bad;
    logic                 last_word;

    logic                 pk_clr, pk_push, pk_full;
    logic [31:0]          pk_word;

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    logic [7:0]           chk_q, chk_d;
`endif

    assign xfer      = In_Valid & In_Ready;
    assign hdr_full  = {hdr_q[LDR_HDR_W-1:8], In_Byte};
    assign hdr_bad   = (hdr_full == '0) || (32'(hdr_full) > WORDS_MAX);
    assign last_word = (32'(word_cnt_q) == (32'(hdr_q) - 32'd1));

    byte_packer u_packer (
        .clk     (CLK),
        .rst     (CLR),
        .clr     (pk_clr),
        .push    (pk_push),
        .byte_in (In_Byte),
        .word    (pk_word),
        .full    (pk_full)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q    <= ST_IDLE;
            hdr_q      <= '0;
            word_cnt_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            word_cnt_q <= word_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (Start) state_d = ST_HDR_HI;
            ST_HDR_HI: if (xfer) state_d = ST_HDR_LO;
            ST_HDR_LO: if (xfer) state_d = hdr_bad ? ST_ERROR : ST_DATA;
            ST_DATA:   if (xfer && pk_full) state_d = ST_WRITE;
            ST_WRITE: begin
                if (!last_word)
                    state_d = ST_DATA;
                else begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_CHK: begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                if (xfer) state_d = (In_Byte == chk_q) ? ST_DONE : ST_ERROR;
`else
                // Unreachable without the trailer; park safely.
                state_d = ST_ERROR;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write address/data are latched when the completing byte arrives so they are
    // valid throughout WRITE and hold afterwards.
    always_comb begin
        hdr_d      = hdr_q;
        word_cnt_d = word_cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        pk_clr     = 1'b0;
        pk_push    = 1'b0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            ST_HDR_HI: begin
                if (xfer) hdr_d[LDR_HDR_W-1:8] = In_Byte;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                chk_d = '0;
`endif
            end
            ST_HDR_LO: begin
                if (xfer) begin
                    hdr_d      = hdr_full;
                    word_cnt_d = '0;
                    pk_clr     = 1'b1;
                end
            end
            ST_DATA: begin
                pk_push = xfer;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                if (xfer) chk_d = chk_q ^ In_Byte;
`endif
                if (xfer && pk_full) begin
                    wr_addr_d = word_cnt_q;
                    wr_data_d = pk_word;
                end
            end
            ST_WRITE: begin
                if (!last_word) word_cnt_d = word_cnt_q + AW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        In_Ready  = 1'b0;
        Wr_En     = 1'b0;
        Cpu_En    = 1'b0;
        Cpu_Clr_N = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        Err       = 1'b0;
        case (state_q)
            ST_HDR_HI, ST_HDR_LO, ST_DATA, ST_CHK: begin
                In_Ready = 1'b1;
                Busy     = 1'b1;
            end
            ST_WRITE: begin
                Wr_En = 1'b1;
                Busy  = 1'b1;
            end
            ST_DONE: begin
                Cpu_En    = 1'b1;
                Cpu_Clr_N = 1'b1;
                Done      = 1'b1;
            end
            ST_ERROR: Err = 1'b1;
            default: ;
        endcase
    end

    assign Wr_Addr = wr_addr_q;
    assign Wr_Data = wr_data_q;

endmodule
